// File: rtl/arb_pkg.sv
// Types shared by the writeback arbiter and its one-entry hold buffer.
package arb_pkg;

  localparam int unsigned DEFER_CNT_W = 4;

  typedef logic [4:0]             reg_addr_t;
  typedef logic [DEFER_CNT_W-1:0] defer_cnt_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } wb_arb_state_t;

endpackage : arb_pkg

// File: rtl/decoder_pkg.sv
// Shared datapath types for the decode/execute/writeback stages.
package decoder_pkg;

  typedef logic [31:0] word;

endpackage : decoder_pkg

// File: rtl/wb_hold_buf.sv
// One-entry holding register for a multi-cycle result waiting for the
// register-file write port. A load wins over a same-cycle clear (refill).
module wb_hold_buf
  import arb_pkg::*;
  import decoder_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      load_i,
  input  logic      clear_i,
  input  logic      discard_i,
  input  reg_addr_t rd_i,
  input  word       data_i,
  output logic      valid_o,
  output reg_addr_t rd_o,
  output word       data_o
);

  logic      valid_q;
  reg_addr_t rd_q;
  word       data_q;

  // NOTE: this is a single register, not a memory array, so it is cheap to
  // reset the data too; that keeps rf_data free of X after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state is always assigned with <= so every flop
      // samples the pre-edge values, regardless of statement order.
      valid_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      rd_q    <= rd_i;
      data_q  <= data_i;
    end else if (clear_i || discard_i) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
    end
  end

  assign valid_o = valid_q;
  assign rd_o    = rd_q;
  assign data_o  = data_q;

endmodule : wb_hold_buf

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, a
// multi-cycle result bypasses, buffers, or forces a one-cycle stall to drain.
module wb_arbiter
  import arb_pkg::*;
  import decoder_pkg::*;
#(
  parameter int unsigned MAX_DEFER = 4
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      pipe_we,
  input  reg_addr_t pipe_rd,
  input  word       pipe_data,
  input  logic      mc_valid,
  input  reg_addr_t mc_rd,
  input  word       mc_data,
  output logic      mc_ready,
  output logic      rf_we,
  output reg_addr_t rf_addr,
  output word       rf_data,
  output logic      stall,
  output logic      pend_valid,
  output reg_addr_t pend_rd
);

  localparam defer_cnt_t DEFER_LIMIT = defer_cnt_t'(MAX_DEFER);

  wb_arb_state_t state_q, state_d;
  defer_cnt_t    cnt_q, cnt_d;

  logic preq, mreq;
  logic drain, discard, load;
  logic ready_c, rf_we_c, stall_c;
  word  buf_data;

  assign preq = pipe_we && (pipe_rd != '0);
  assign mreq = mc_valid && (mc_rd != '0);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rf_we_c = 1'b0;
    rf_addr = '0;
    rf_data = '0;
    stall_c = 1'b0;
    drain   = 1'b0;
    discard = 1'b0;

    unique case (state_q)
      FORCE: begin
        stall_c = 1'b1;
        rf_we_c = 1'b1;
        rf_addr = pend_rd;
        rf_data = buf_data;
        drain   = 1'b1;
      end
      PEND: begin
        if (preq) begin
          rf_we_c = 1'b1;
          rf_addr = pipe_rd;
          rf_data = pipe_data;
          // A younger pipeline write to the same register makes the buffer stale.
          if (pipe_rd == pend_rd) begin
            discard = 1'b1;
          end else begin
            cnt_d = cnt_q + defer_cnt_t'(1);
            if (cnt_d == DEFER_LIMIT) state_d = FORCE;
          end
        end else begin
          rf_we_c = 1'b1;
          rf_addr = pend_rd;
          rf_data = buf_data;
          drain   = 1'b1;
        end
      end
      default: begin
        if (preq) begin
          rf_we_c = 1'b1;
          rf_addr = pipe_rd;
          rf_data = pipe_data;
        end else if (mreq) begin
          rf_we_c = 1'b1;
          rf_addr = mc_rd;
          rf_data = mc_data;
        end
      end
    endcase

    ready_c = !pend_valid || drain;
    // Captured unless the result took the free port directly (EMPTY bypass).
    load    = mreq && ready_c && !(state_q == EMPTY && !preq);

    if (drain || discard) begin
      state_d = EMPTY;
      cnt_d   = '0;
    end
    if (load) begin
      state_d = PEND;
      cnt_d   = '0;
    end
  end

  assign mc_ready = reset_n && ready_c;
  assign rf_we    = reset_n && rf_we_c;
  assign stall    = reset_n && stall_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  wb_hold_buf u_hold_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (load),
    .clear_i   (drain),
    .discard_i (discard),
    .rd_i      (mc_rd),
    .data_i    (mc_data),
    .valid_o   (pend_valid),
    .rd_o      (pend_rd),
    .data_o    (buf_data)
  );

endmodule : wb_arbiter

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected register-file writes are queued as
// stimulus is driven and popped whenever the write port is sampled.
module tb_wb_arbiter;
  import arb_pkg::*;
  import decoder_pkg::*;

  typedef struct packed {
    reg_addr_t addr;
    word       data;
  } wr_t;

  logic      clk = 1'b0;
  logic      reset_n;
  logic      pipe_we;
  reg_addr_t pipe_rd;
  word       pipe_data;
  logic      mc_valid;
  reg_addr_t mc_rd;
  word       mc_data;
  logic      mc_ready;
  logic      rf_we;
  reg_addr_t rf_addr;
  word       rf_data;
  logic      stall;
  logic      pend_valid;
  reg_addr_t pend_rd;

  int  checks = 0;
  int  errors = 0;
  wr_t sb_q[$];

  always #5 clk = ~clk;

  wb_arbiter #(.MAX_DEFER(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pipe_we    (pipe_we),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .mc_valid   (mc_valid),
    .mc_rd      (mc_rd),
    .mc_data    (mc_data),
    .mc_ready   (mc_ready),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .stall      (stall),
    .pend_valid (pend_valid),
    .pend_rd    (pend_rd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pwe, input reg_addr_t prd, input word pdata,
                       input logic mv, input reg_addr_t mrd, input word mdata);
    pipe_we   = pwe;
    pipe_rd   = prd;
    pipe_data = pdata;
    mc_valid  = mv;
    mc_rd     = mrd;
    mc_data   = mdata;
    #1;
  endtask

  task automatic push(input reg_addr_t addr, input word data);
    sb_q.push_back('{addr: addr, data: data});
  endtask

  // Sample the write port mid-cycle, then step to just past the next edge.
  task automatic tick(input string tag, input logic exp_we);
    wr_t e;
    @(negedge clk);
    check({tag, ".rf_we"}, 32'(rf_we), 32'(exp_we));
    if (exp_we && rf_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s.scoreboard: observed write x%0d with no expected entry", tag, rf_addr);
      end else begin
        e = sb_q.pop_front();
        check({tag, ".rf_addr"}, 32'(rf_addr), 32'(e.addr));
        check({tag, ".rf_data"}, rf_data, e.data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset: outputs forced low even with active requests.
    reset_n = 1'b0;
    drive(1'b1, 5'd3, 32'h3, 1'b1, 5'd5, 32'h5);
    #2;
    check("rst.mc_ready", 32'(mc_ready), 32'd0);
    check("rst.rf_we", 32'(rf_we), 32'd0);
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.pend_valid", 32'(pend_valid), 32'd0);
    check("rst.pend_rd", 32'(pend_rd), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    reset_n = 1'b1;
    #1;
    check("rel.mc_ready", 32'(mc_ready), 32'd1);
    check("rel.stall", 32'(stall), 32'd0);

    // Bypass: free port, zero-latency write, nothing buffered.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    check("byp.mc_ready", 32'(mc_ready), 32'd1);
    push(5'd5, 32'hDEAD_BEEF);
    tick("byp", 1'b1);
    check("byp.pend_valid", 32'(pend_valid), 32'd0);

    // Buffer then drain.
    drive(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd7, 32'h0000_0077);
    push(5'd3, 32'h0000_0033);
    tick("buf", 1'b1);
    check("buf.pend_valid", 32'(pend_valid), 32'd1);
    check("buf.pend_rd", 32'(pend_rd), 32'd7);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("drn.stall", 32'(stall), 32'd0);
    push(5'd7, 32'h0000_0077);
    tick("drn", 1'b1);
    check("drn.pend_valid", 32'(pend_valid), 32'd0);

    // Forced drain after MAX_DEFER blocked cycles.
    drive(1'b1, 5'd2, 32'h0000_2000, 1'b1, 5'd9, 32'h0000_9999);
    push(5'd2, 32'h0000_2000);
    tick("frc.cap", 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd2, 32'h0000_2001 + 32'(i), 1'b0, 5'd0, 32'h0);
      check("frc.defer.stall", 32'(stall), 32'd0);
      check("frc.defer.mc_ready", 32'(mc_ready), 32'd0);
      check("frc.defer.pend_valid", 32'(pend_valid), 32'd1);
      push(5'd2, 32'h0000_2001 + 32'(i));
      tick("frc.defer", 1'b1);
    end
    drive(1'b1, 5'd2, 32'h0000_2005, 1'b0, 5'd0, 32'h0);
    check("frc.stall", 32'(stall), 32'd1);
    check("frc.mc_ready", 32'(mc_ready), 32'd1);
    push(5'd9, 32'h0000_9999);
    tick("frc.drain", 1'b1);
    check("frc.after.stall", 32'(stall), 32'd0);
    check("frc.after.pend_valid", 32'(pend_valid), 32'd0);
    push(5'd2, 32'h0000_2005);
    tick("frc.replay", 1'b1);

    // WAW discard: younger pipeline write to the buffered register wins.
    drive(1'b1, 5'd1, 32'h0000_0001, 1'b1, 5'd6, 32'h0000_0011);
    push(5'd1, 32'h0000_0001);
    tick("waw.cap", 1'b1);
    check("waw.pend_rd", 32'(pend_rd), 32'd6);
    drive(1'b1, 5'd6, 32'h0000_0022, 1'b0, 5'd0, 32'h0);
    check("waw.mc_ready", 32'(mc_ready), 32'd0);
    push(5'd6, 32'h0000_0022);
    tick("waw.pipe", 1'b1);
    check("waw.pend_valid", 32'(pend_valid), 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick("waw.idle", 1'b0);

    // x0 result accepted and dropped.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0000_0055);
    check("x0.mc_ready", 32'(mc_ready), 32'd1);
    tick("x0", 1'b0);
    check("x0.pend_valid", 32'(pend_valid), 32'd0);

    // Refill: x4 captured, x8 accepted while x4 drains.
    drive(1'b1, 5'd11, 32'h0000_000B, 1'b1, 5'd4, 32'h0000_0044);
    check("rfl.mc_ready0", 32'(mc_ready), 32'd1);
    push(5'd11, 32'h0000_000B);
    tick("rfl.cap", 1'b1);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h0000_0088);
    check("rfl.mc_ready1", 32'(mc_ready), 32'd1);
    push(5'd4, 32'h0000_0044);
    tick("rfl.drain4", 1'b1);
    check("rfl.pend_valid", 32'(pend_valid), 32'd1);
    check("rfl.pend_rd", 32'(pend_rd), 32'd8);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    push(5'd8, 32'h0000_0088);
    tick("rfl.drain8", 1'b1);
    check("rfl.empty", 32'(pend_valid), 32'd0);

    // Reset mid-pend: buffered x10 is lost.
    drive(1'b1, 5'd12, 32'h0000_000C, 1'b1, 5'd10, 32'h0000_00A0);
    push(5'd12, 32'h0000_000C);
    tick("rmp.cap", 1'b1);
    check("rmp.pend_valid0", 32'(pend_valid), 32'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    reset_n = 1'b0;
    #1;
    check("rmp.pend_valid", 32'(pend_valid), 32'd0);
    check("rmp.pend_rd", 32'(pend_rd), 32'd0);
    check("rmp.stall", 32'(stall), 32'd0);
    check("rmp.rf_we", 32'(rf_we), 32'd0);
    check("rmp.mc_ready", 32'(mc_ready), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("rmp.rel.mc_ready", 32'(mc_ready), 32'd1);
    for (int i = 0; i < 3; i++) tick("rmp.idle", 1'b0);

    check("sb.leftover", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_wb_arbiter

// File: doc/wb_arbiter.md
# wb_arbiter

Shares the single register-file write port between the in-order pipeline writeback (the `wb_mux` output) and one multi-cycle unit, such as a divider, that returns results out of band. Pipeline writes have priority. A multi-cycle result goes to the register file directly when the port is free; otherwise it is held in a one-entry buffer and drained in the next free cycle. If the buffer is blocked for `MAX_DEFER` consecutive cycles, the block stalls the pipeline for one cycle to force the drain. The block sits between the writeback stage and the register file and also feeds the hazard unit with the pending destination register.

## Interface
- `MAX_DEFER`, default 4: consecutive blocked cycles tolerated before a forced drain; legal range 1..15.
- `clk` in 1: core clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `pipe_we` in 1: pipeline writeback request this cycle.
- `pipe_rd` in 5: pipeline destination register.
- `pipe_data` in `word`: pipeline writeback value (`wb_mux` out).
- `mc_valid` in 1: multi-cycle result valid.
- `mc_rd` in 5: multi-cycle destination register.
- `mc_data` in `word`: multi-cycle result.
- `mc_ready` out 1: block accepts the multi-cycle result this cycle.
- `rf_we` out 1: register-file write enable.
- `rf_addr` out 5: register-file write address.
- `rf_data` out `word`: register-file write data.
- `stall` out 1: freezes the pipeline for this cycle; the pipeline re-presents the same writeback next cycle.
- `pend_valid` out 1: buffer holds an unwritten result.
- `pend_rd` out 5: destination of the buffered result, for hazard detection.

## Operation
- Effective pipeline request: `preq = pipe_we && pipe_rd != 0`. Effective multi-cycle request: `mc_valid && mc_rd != 0`.
- A multi-cycle handshake completes when `mc_valid && mc_ready`. If `mc_rd == 0`, the result is accepted and dropped.
- `mc_ready = !pend_valid || drain`, where `drain` means the buffer writes this cycle. The buffer therefore refills in the same cycle it drains.
- State (`wb_arb_state_t`):
  - EMPTY: buffer empty.
  - PEND: buffer valid, defer count below `MAX_DEFER`.
  - FORCE: buffer valid, defer count equals `MAX_DEFER`.
- Port grant, combinational, evaluated in priority order:
  1. FORCE: `stall = 1`. The buffer writes; the pipeline write is suppressed.
  2. PEND with `!preq`: the buffer writes.
  3. PEND with `preq`: the pipeline writes; the defer count increments.
  4. EMPTY with `preq`: the pipeline writes. An accepted multi-cycle result is captured into the buffer.
  5. EMPTY with `!preq` and a multi-cycle request: the multi-cycle result bypasses the buffer and writes directly, with zero latency and no buffering.
  6. Otherwise: `rf_we = 0`.
- WAW rule: in PEND, if `preq && pipe_rd == pend_rd`, the pipeline value wins because it is younger.
  - The buffer entry is discarded that cycle and the state goes to EMPTY.
  - This does not apply in FORCE, where the pipeline is stalled.
- Transitions:
  - EMPTY→PEND: result captured (case 4).
  - PEND→EMPTY: drained or discarded with no new capture.
  - PEND→PEND: drained and refilled in the same cycle; the count is cleared to 0.
  - PEND→FORCE: the count reaches `MAX_DEFER`.
  - FORCE→EMPTY or FORCE→PEND: always exits after one cycle (PEND if refilled).
- Defer count: width 4. Cleared to 0 on capture, drain and discard. Never exceeds `MAX_DEFER`.

## Timing
- Write-port outputs and `stall` are combinational from the inputs and the state. Buffer, count and state are registered on `clk` rising.
- Latency from handshake to register-file write:
  - 0 cycles when bypassed.
  - 1..`MAX_DEFER` cycles when buffered without forcing.
  - At most `MAX_DEFER` + 1 cycles in the worst case.
- `pend_valid` and `pend_rd` are registered. They assert the cycle after capture and deassert the cycle after drain or discard.
- Reset, asynchronous while `reset_n` is low:
  - State EMPTY, count 0, buffer cleared, `pend_rd` = 0.
  - Outputs forced to `rf_we = 0`, `stall = 0`, `mc_ready = 0`.
  - A pending result is lost on reset mid-operation.
- Release: `mc_ready` rises combinationally once `reset_n` is high.

## Structure
- Package `arb_pkg`: `wb_arb_state_t` (EMPTY, PEND, FORCE) and the `reg_addr_t` 5-bit typedef.
- `word` comes from `decoder_pkg`.
- Sub-module `wb_hold_buf`: the one-entry rd/data register with valid, load, clear and discard. The grant and state logic stays in `wb_arbiter`.

## Test plan
- **Bypass.** `pipe_we = 0`, `mc_valid = 1`, `mc_rd = 5`, `mc_data = 0xDEAD_BEEF` → same cycle `rf_we = 1`, `rf_addr = 5`, `rf_data = 0xDEAD_BEEF`; `pend_valid` stays 0.
- **Buffer then drain.** `pipe_we = 1`, `pipe_rd = 3`, `mc_valid = 1`, `mc_rd = 7` → pipeline writes x3. Next cycle, with `pipe_we = 0` → `rf_addr = 7` with the captured data, and `pend_valid` falls one cycle later.
- **Forced drain.** `MAX_DEFER = 4`, buffered x9, `pipe_we` held 1 with `pipe_rd = 2` → pipeline writes for 4 cycles, then `stall = 1` and the x9 write; the pipeline write of x2 lands the following cycle.
- **WAW discard.** Buffered x6 = 0x11, then `pipe_we = 1`, `pipe_rd = 6`, `pipe_data = 0x22` → x6 = 0x22 is written and the buffer is never written; `pend_valid` = 0 next cycle.
- **x0 and refill.** `mc_rd = 0` is accepted and dropped with no `rf_we`. Back-to-back `mc_valid` on x4 then x8 during drain → `mc_ready` stays 1 and both are written in order.
- **Reset mid-pend.** Buffered x10, then `reset_n` pulsed low asynchronously → `pend_valid = 0`, `stall = 0`, and x10 is never written.
